// File: rtl/mem_access_unit.sv
// Data-memory access stage: one bus transaction per load/store, then an aligned, extended response.
// Optional build macro MAU_MISALIGN_CHK_EN rejects misaligned half/word accesses without using the bus.
module mem_access_unit #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic [TO_W-1:0]  cnt_q;
   logic [1:0]       off_q;
   logic [2:0]       funct3_q;
   logic             store_q;

   logic             req_ready_q;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [3:0]       mem_be_q;
   logic [31:0]      mem_wdata_q;
   logic             resp_valid_q;
   logic [31:0]      resp_rdata_q;
   logic             resp_err_q;

   logic [1:0]       off_d;
   logic [3:0]       be_d;
   logic [31:0]      wdata_d;
   logic             misalign_d;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      load_d;
   logic             accept;
   logic             timeout_hit;

   assign off_d       = req_addr[1:0];
   assign accept      = req_valid && req_ready_q;
   assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));

   // Lane strobes and replicated store data for the incoming request
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = req_wdata;
      case (req_funct3[1:0])
         2'd0: begin
            be_d    = 4'b0001 << off_d;
            wdata_d = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            be_d    = 4'b0011 << {off_d[1], 1'b0};
            wdata_d = {2{req_wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = req_wdata;
         end
      endcase
   end

`ifdef MAU_MISALIGN_CHK_EN
   always_comb begin
      misalign_d = 1'b0;
      case (req_funct3[1:0])
         2'd0:    misalign_d = 1'b0;
         2'd1:    misalign_d = off_d[0];
         default: misalign_d = (off_d != 2'b00);
      endcase
   end
`else
   assign misalign_d = 1'b0;
`endif

   // Load lane select uses the offset latched at accept time
   assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
   assign rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      load_d = mem_rdata;
      case (funct3_q[1:0])
         2'd0:    load_d = funct3_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'd1:    load_d = funct3_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: load_d = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         off_q        <= 2'b00;
         funct3_q     <= 3'b000;
         store_q      <= 1'b0;
         req_ready_q  <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (accept) begin
                  req_ready_q <= 1'b0;
                  off_q       <= off_d;
                  funct3_q    <= req_funct3;
                  store_q     <= req_store;
                  cnt_q       <= '0;
                  if (misalign_d) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     state_q     <= S_BUS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_store;
                     mem_addr_q  <= {req_addr[31:2], 2'b00};
                     mem_be_q    <= be_d;
                     mem_wdata_q <= wdata_d;
                  end
               end
            end
            S_BUS: begin
               // An ack in the final timeout cycle still completes normally
               if (mem_ack) begin
                  state_q      <= S_RESP;
                  mem_req_q    <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= mem_err;
                  resp_rdata_q <= (mem_err || store_q) ? 32'h0 : load_d;
               end else if (timeout_hit) begin
                  state_q      <= S_RESP;
                  mem_req_q    <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q      <= S_IDLE;
               mem_req_q    <= 1'b0;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized transactions against a reference model.
module tb_mem_access_unit;
   localparam int TO_W    = 8;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic        mem_err = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int off = int'(a[1:0]);
      case (f3[1:0])
         2'd0:    return 4'(1 << off);
         2'd1:    return 4'(3 << (off & 2));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
         2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      int off = int'(a[1:0]);
      logic [31:0] v;
      case (f3[1:0])
         2'd0: begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            v = (rd >> (8 * (off & 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = rd;
      endcase
      return v;
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MAU_MISALIGN_CHK_EN
      if (f3[1:0] == 2'd1) return a[0];
      if (f3[1:0] >= 2'd2) return (a[1:0] != 2'b00);
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   // ack_at = cycle (counted from accept) in which mem_ack is driven; 0 means never
   task automatic run_txn(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rd, input logic err, input bit stray_ack);
      int waitc = 0;
      int c = 1;
      int req_cnt = 0;
      int bad = 0;
      int resp_c = 0;
      int exp_k;
      bit mis;
      logic exp_err;
      logic [31:0] exp_rd;
      logic        f_we = 1'b0;
      logic [31:0] f_addr = 32'h0, f_wdata = 32'h0;
      logic [3:0]  f_be = 4'h0;

      while (!req_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready) begin
         check_eq({name, "_ready"}, 32'(req_ready), 32'd1);
         return;
      end
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      mem_ack    = stray_ack;
      mem_err    = stray_ack;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;

      while (c <= 2 * TIMEOUT) begin
         if (resp_valid) begin
            resp_c = c;
            break;
         end
         if (c == 1) begin
            f_we = mem_we; f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata;
         end
         if (mem_req) begin
            req_cnt++;
            if (mem_we !== f_we || mem_addr !== f_addr || mem_be !== f_be || mem_wdata !== f_wdata)
               bad++;
         end
         if (c == ack_at) begin
            mem_ack = 1'b1; mem_err = err; mem_rdata = rd;
         end
         @(negedge clk);
         mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
         c++;
      end

      mis = ref_misaligned(f3, addr);
      if (mis) begin
         exp_err = 1'b1;
         check_eq({name, "_resp_cycle"}, 32'(resp_c), 32'd1);
         check_eq({name, "_req_cycles"}, 32'(req_cnt), 32'd0);
      end else begin
         exp_k   = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
         exp_err = (ack_at >= 1 && ack_at <= TIMEOUT) ? err : 1'b1;
         check_eq({name, "_resp_cycle"}, 32'(resp_c), 32'(exp_k + 1));
         check_eq({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_k));
         check_eq({name, "_we"}, 32'(f_we), 32'(st));
         check_eq({name, "_addr"}, f_addr, addr & 32'hFFFF_FFFC);
         check_eq({name, "_be"}, 32'(f_be), 32'(ref_be(f3, addr)));
         if (st) check_eq({name, "_wdata"}, f_wdata, ref_wdata(f3, wd));
         check_eq({name, "_bus_stable"}, 32'(bad), 32'd0);
      end
      exp_rd = (exp_err || st) ? 32'h0 : ref_load(f3, addr, rd);
      check_eq({name, "_err"}, 32'(resp_err), 32'(exp_err));
      check_eq({name, "_rdata"}, resp_rdata, exp_rd);
      $display("txn %s st=%0d f3=%0d addr=%08h ack_at=%0d -> cyc=%0d rdata=%08h err=%0d",
               name, st, f3, addr, ack_at, resp_c, resp_rdata, resp_err);
      @(negedge clk);
      check_eq({name, "_pulse"}, 32'(resp_valid), 32'd0);
      check_eq({name, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [1:0] sz;
      logic [2:0] f3;
      logic       st;
      int         ack_at;
      int         seen;

      #2;
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn("LB",      1'b0, 3'd0, 32'h0000_1003, 32'h0, 2, 32'h80FF_0000, 1'b0, 1'b0);
      run_txn("LHU",     1'b0, 3'd5, 32'h0000_2002, 32'h0, 1, 32'h8001_1234, 1'b0, 1'b0);
      run_txn("SB",      1'b1, 3'd0, 32'h0000_3001, 32'h0000_00AB, 1, 32'h1234_5678, 1'b0, 1'b1);
      run_txn("TIMEOUT", 1'b0, 3'd2, 32'h0000_5000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn("ACK_AT_TO", 1'b0, 3'd2, 32'h0000_5004, 32'h0, TIMEOUT, 32'hCAFE_F00D, 1'b0, 1'b0);
      run_txn("LW_MIS",  1'b0, 3'd2, 32'h0000_4002, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
      run_txn("BUS_ERR", 1'b0, 3'd2, 32'h0000_6000, 32'h0, 3, 32'h1111_2222, 1'b1, 1'b0);
      run_txn("LH_SX",   1'b0, 3'd1, 32'h0000_7000, 32'h0, 1, 32'h1234_F00F, 1'b0, 1'b0);

      // Reset in the middle of a bus cycle
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_8000;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("rstmid_req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstmid_req_drop", 32'(mem_req), 32'd0);
      check_eq("rstmid_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check_eq("rstmid_no_resp", 32'(seen), 32'd0);
      check_eq("rstmid_ready_after", 32'(req_ready), 32'd1);
      run_txn("POST_RST", 1'b0, 3'd4, 32'h0000_9002, 32'h0, 2, 32'h00A5_5A00, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         sz     = 2'($urandom_range(0, 2));
         st     = 1'($urandom_range(0, 1));
         f3     = st ? {1'b0, sz} : {1'($urandom_range(0, 1)), sz};
         ack_at = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6));
         run_txn($sformatf("RND%0d", n), st, f3, $urandom, $urandom, ack_at, $urandom,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
